// File: rtl/add_round_key_stage_pkg.sv
// Shared AES constants, types and the round-counter state encoding.
package add_round_key_stage_pkg;

    localparam int AES_NR    = 10;
    localparam int AES_NK    = 4;
    localparam int STATE_W   = 32 * AES_NK;
    localparam int KEY_IDX_W = 4;

    typedef logic [STATE_W-1:0]   state_t;
    typedef logic [KEY_IDX_W-1:0] round_idx_t;

    // Round phases: the first and last rounds take the shr_in path, the
    // middle rounds take the MixColumns path.
    typedef enum logic [1:0] {
        ROUND_0 = 2'd0,
        MID     = 2'd1,
        FINAL   = 2'd2
    } round_state_e;

    // Phase a given round index belongs to, for a cipher with nr rounds.
    function automatic round_state_e state_of(input round_idx_t r, input round_idx_t nr);
        if (r == '0) begin
            return ROUND_0;
        end else if (r == nr) begin
            return FINAL;
        end
        return MID;
    endfunction

endpackage

// File: rtl/add_round_key_stage_round_key_file.sv
// Round-key file: NUM_KEYS x 128-bit registers, one write port, one
// combinational read port. Reads see the value before a same-edge write.
module round_key_file
    import add_round_key_stage_pkg::*;
#(
    parameter int NUM_KEYS = AES_NR + 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  round_idx_t wr_idx,
    input  state_t     wr_data,
    input  round_idx_t rd_idx,
    output state_t     rd_data
);

    localparam round_idx_t NUM_KEYS_IDX = round_idx_t'(NUM_KEYS);

    state_t key_q [NUM_KEYS];
    state_t key_d [NUM_KEYS];

    // Next key-file contents: apply an in-range write, ignore out-of-range indices.
    always_comb begin
        // NOTE: start from the held value so every path assigns key_d and no latch is inferred.
        key_d = key_q;
        if (wr_en && (wr_idx < NUM_KEYS_IDX)) begin
            key_d[wr_idx] = wr_data;
        end
    end

    assign rd_data = (rd_idx < NUM_KEYS_IDX) ? key_q[rd_idx] : '0;

    // Key storage register, cleared by reset so keys must be reloaded afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this storage is flops, not a RAM macro, so it can and must be reset to zero.
            for (int i = 0; i < NUM_KEYS; i++) begin
                key_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking so the read port in this cycle still sees the old key.
            key_q <= key_d;
        end
    end

endmodule

// File: rtl/add_round_key_stage.sv
// Registered AddRoundKey stage of the iterative AES-128 encryption datapath.
// Tracks the current round, selects plaintext / MixColumns / ShiftRows input,
// XORs it with that round's key and holds the result in a one-entry output
// register behind a valid/ready handshake.
module add_round_key_stage
    import add_round_key_stage_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 abort,
    input  logic                 key_wr_en,
    input  logic [KEY_IDX_W-1:0] key_wr_idx,
    input  logic [STATE_W-1:0]   key_wr_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [STATE_W-1:0]   mix_in,
    input  logic [STATE_W-1:0]   shr_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [STATE_W-1:0]   out,
    output logic [KEY_IDX_W-1:0] out_round,
    output logic                 last,
    output logic [KEY_IDX_W-1:0] round
);

    localparam round_idx_t NR_IDX = round_idx_t'(NR);

    round_state_e state_q,     state_d;
    round_idx_t   round_q,     round_d;
    state_t       out_q,       out_d;
    round_idx_t   out_round_q, out_round_d;
    logic         last_q,      last_d;
    logic         out_valid_q, out_valid_d;

    state_t round_key;
    state_t sel;
    logic   accept;

    round_key_file #(
        .NUM_KEYS (NR + 1)
    ) u_key_file (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (key_wr_en),
        .wr_idx  (key_wr_idx),
        .wr_data (key_wr_data),
        .rd_idx  (round_q),
        .rd_data (round_key)
    );

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign sel      = (state_q == MID) ? mix_in : shr_in;

    // Next-state: abort beats accept, accept beats a plain drain of the output.
    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        out_d       = out_q;
        out_round_d = out_round_q;
        last_d      = last_q;
        out_valid_d = out_valid_q;
        if (abort) begin
            round_d     = '0;
            state_d     = ROUND_0;
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_d       = sel ^ round_key;
            out_round_d = round_q;
            last_d      = (state_q == FINAL);
            out_valid_d = 1'b1;
            round_d     = (state_q == FINAL) ? '0 : round_q + round_idx_t'(1);
            state_d     = state_of(round_d, NR_IDX);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Round counter, FSM state and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ROUND_0;
            round_q     <= '0;
            out_q       <= '0;
            out_round_q <= '0;
            last_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            out_q       <= out_d;
            out_round_q <= out_round_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_round = out_round_q;
    assign last      = last_q;
    assign out_valid = out_valid_q;
    assign round     = round_q;

endmodule

// File: doc/add_round_key_stage.md
Name: add_round_key_stage

Overview:
- Registered AddRoundKey stage of the iterative AES-128 encryption datapath. It sits directly downstream of the combinational MixColumns block.
- It holds the 11 round keys in a local key file and tracks the current round. Per accepted beat it XORs the selected state with the round key for that round.
- Round 0 takes the plaintext, rounds 1..NR-1 take the MixColumns output, and round NR takes the ShiftRows output (MixColumns bypassed).
- Result is presented on a valid/ready interface; it feeds SubBytes of the next round and the ciphertext sink.

Parameters:
NR, 10, number of AES rounds; key file holds NR+1 round keys, index width 4.

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
abort  input  1  synchronous clear of round counter and output register
key_wr_en  input  1  round-key file write strobe
key_wr_idx  input  4  round-key index 0..NR
key_wr_data  input  128  round key, byte 0 in [127:120]
in_valid  input  1  input beat valid
in_ready  output  1  stage can accept a beat
mix_in  input  128  MixColumns output (rounds 1..NR-1)
shr_in  input  128  plaintext (round 0) or ShiftRows output (round NR)
out_valid  output  1  out holds a result
out_ready  input  1  downstream accepts out
out  output  128  state XOR round key
out_round  output  4  round index that produced out
last  output  1  out is ciphertext (out_round == NR)
round  output  4  round index the next accepted beat will use

Behaviour:
- Reset (rst_n low, async): round=0, out=0, out_round=0, last=0, out_valid=0, all key-file entries=0. in_ready is 1 after reset.
- in_ready = !out_valid || out_ready, combinational; one-entry output register, full throughput.
- Accept = in_valid && in_ready. On accept, next cycle:
  - out = sel ^ key[round];
  - sel = shr_in when round==0 or round==NR, else mix_in;
  - out_valid=1, out_round=round, last=(round==NR);
  - round increments, wrapping NR -> 0.
- Latency: 1 cycle from accept to out_valid.
- out_valid falls when out_ready=1 and there is no accept in the same cycle. out and out_round are held stable while out_valid=1 and out_ready=0.
- Round counter FSM: states ROUND_0, MID (1..NR-1), FINAL (NR).
  - ROUND_0 -> MID -> ... -> FINAL -> ROUND_0, advancing only on accept.
  - No other transitions except abort/reset.
- Key file write: on key_wr_en with key_wr_idx<=NR, the entry updates at the edge. key_wr_idx>NR is ignored.
- Write and accept to the same index in the same cycle: the accept uses the old key (read-before-write).
- abort=1: round=0 and out_valid=0 next cycle, and any same-cycle accept is discarded. Key file and out data are unchanged. abort has priority over accept.
- Async reset mid-block: everything returns to reset values immediately, including the key file, which must be reloaded.
- in_ready is not gated by the key-file state; loading keys before the first beat is the responsibility of the upstream controller.

Decomposition:
- Shared aes package:
  - constants AES_NR=10, AES_NK=4, STATE_W=128, KEY_IDX_W=4;
  - typedefs state_t (128-bit) and round_idx_t (4-bit).
- One natural sub-module: round_key_file, holding (NR+1) x 128 registers with async reset, one write port and one combinational read port.
- Round counter, select mux and output register stay in the top module.

Test Plan:
- FIPS-197 App. B round 0: load key[0]=2b7e151628aed2a6abf7158809cf4f3c; beat with shr_in=3243f6a8885a308d313198a2e0370734 -> out=193de3bea0f4e22b9ac68d2ae9f84808, out_round=0, last=0, round becomes 1.
- Round 1: key[1]=a0fafe1788542cb123a339392a6c7605; mix_in=046681e5e0cb199a48f8d37a2806264c with shr_in=0 -> out=a49c7ff2689f352b6b5bea43026a5049.
- Final-round bypass: advance to round=10, key[10]=all FF, shr_in=0, mix_in=all 55 -> out=all FF, last=1, round wraps to 0.
- Backpressure: hold out_ready=0 with out_valid=1 and in_valid=1 -> in_ready=0, out stable, round unchanged. Release out_ready -> beat accepted the same cycle, new out next cycle.
- Same-cycle hazard: write key[0]=all 11 while accepting round-0 beat shr_in=0 with old key[0]=0 -> out=0. Next round-0 beat -> out=all 11.
- Abort and reset: abort at round=5 with out_valid=1 -> next cycle round=0, out_valid=0. Pulse rst_n low mid-beat -> out_valid=0 immediately and key[3] reads 0.
